mem_stage_wb: RTL and testbench
===============================

Name: mem_stage_wb

Overview:
- Consumer end of the EX/MEM pipeline register in the vector ASIP.
- Takes the 48-bit ALU result/address, store data, destination register and control bits from the EX/MEM register.
- Performs the data-memory access over a 16-bit request/acknowledge memory port, one beat at a time (3 beats per 48-bit vector).
- Loads the MEM/WB pipeline register and drives stall back to the upstream stages while an access is in progress.

Parameters:
- DATA_W, 48: vector/register data width.
- BEAT_W, 16: memory port data width; DATA_W must be an integer multiple of BEAT_W.
- ADDR_W, 16: memory word-address width; taken from aluResultM[ADDR_W-1:0].

Ports:
- clk  in  1  single clock; all state on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- aluResultM  in  DATA_W  ALU result; base word address for memory ops.
- writeDataM  in  DATA_W  store data.
- WA3M  in  4  destination register.
- validM  in  1  EX/MEM holds a real instruction.
- regWriteM, memWriteM, memToRegM, PCSrcM  in  1 each  control bits.
- stallM  out  1  upstream must hold the EX/MEM contents.
- mem_req  out  1  memory beat request.
- mem_we  out  1  beat is a write.
- mem_addr  out  ADDR_W  beat word address.
- mem_wdata  out  BEAT_W  beat write data.
- mem_rdata  in  BEAT_W  beat read data, valid with mem_ack.
- mem_ack  in  1  beat complete; may be asserted in the same cycle as mem_req.
- aluOutW, readDataW  out  DATA_W  MEM/WB data registers.
- WA3W  out  4  MEM/WB destination register.
- validW, regWriteW, memToRegW, PCSrcW  out  1 each  MEM/WB control registers.

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE and the beat counter to 0.
  - All registered outputs go to 0 immediately: validW, regWriteW, memToRegW, PCSrcW, aluOutW, readDataW, WA3W.
  - mem_req, mem_we and stallM go to 0 immediately. An in-flight access is abandoned; no writeback occurs for it.
- States: IDLE, ACCESS. stallM = (state == ACCESS), decoded from registered state.
- IDLE, validM=0:
  - Next edge writes validW=0 and regWriteW=0 (bubble).
  - Other W fields are don't-care but loaded from the inputs.
- IDLE, validM=1, memWriteM=0, memToRegM=0 (ALU op):
  - Next edge loads all W registers from the M inputs, with validW=1 and readDataW unchanged.
  - Latency 1; no stall.
- IDLE, validM=1, memWriteM or memToRegM set (memory op):
  - Next edge captures all M fields into internal holding registers, clears the beat counter k, and enters ACCESS.
  - The same edge writes validW=0 (bubble).
- memWriteM=1 together with memToRegM=1: treated as a store; memToRegW is written 0.
- ACCESS:
  - mem_req=1; mem_we = held memWrite.
  - mem_addr = base + k, modulo 2^ADDR_W (wrap-around is permitted).
  - mem_wdata = held writeData[k*BEAT_W +: BEAT_W].
  - On an edge with mem_req & mem_ack:
    - Loads capture mem_rdata into assembly slice k.
    - k increments.
  - mem_ack while mem_req=0 is ignored.
  - Without ack, all outputs hold stable.
- Last beat (k = DATA_W/BEAT_W - 1) acknowledged, on that edge:
  - Load all W registers from the held fields, with validW=1.
  - Loads: readDataW = fully assembled vector, including the final beat.
  - Stores: readDataW unchanged.
  - Return to IDLE.
- Next instruction: stallM drops in the following cycle, and the held next instruction is accepted on the edge after that.
- Best-case memory-op timing (ack every cycle): capture edge E0, beats acknowledged at E1..E3, validW=1 after E3; stallM high for cycles E0..E3.
- Upstream inputs are not sampled while in ACCESS.

Decomposition:
- Shared package:
  - State enum typedef.
  - Constants DATA_W, BEAT_W, ADDR_W and BEATS = DATA_W/BEAT_W.
  - A packed struct bundling the control bits (regWrite, memWrite, memToReg, PCSrc, valid, WA3) for the M and W sides.
- One natural sub-module: mem_beat_seq (beat counter, address generation, read-assembly register, request/acknowledge handling).
- Top level holds the FSM and the MEM/WB registers.

Test Plan:
- Reset: hold rst=0 with validM=1 -> all outputs 0, mem_req=0, stallM=0; release -> IDLE.
- ALU op: aluResultM=48'h123456789ABC, WA3M=5, regWriteM=1 -> next cycle aluOutW=48'h123456789ABC, WA3W=5, validW=1, regWriteW=1, stallM never high.
- Load, base=16'h0010, ack every cycle, rdata 16'h1111/16'h2222/16'h3333:
  - Expected addresses: 16'h0010, 16'h0011, 16'h0012.
  - Expected result: readDataW=48'h333322221111, memToRegW=1, validW=1 exactly once, stallM high 3 cycles.
- Store with wait states: writeDataM=48'hAAAABBBBCCCC, ack delayed 2 cycles per beat -> wdata sequence CCCC, BBBB, AAAA; mem_req and wdata stable during waits; validW=1 with regWriteW as given.
- Address wrap: base=16'hFFFF load -> addresses FFFF, 0000, 0001.
- Reset mid-op: assert rst=0 after beat 1 acknowledged -> mem_req drops same cycle, no validW pulse, next instruction processed normally.

Source files
------------

// File: rtl/mem_stage_wb_pkg.sv
// Shared types and sizing for the MEM stage: state encoding, control bundle
// and the per-beat address helper used by the beat sequencer.
package mem_stage_wb_pkg;

   localparam int DATA_W = 48;
   localparam int BEAT_W = 16;
   localparam int ADDR_W = 16;
   localparam int BEATS  = DATA_W / BEAT_W;
   localparam int K_W    = (BEATS > 1) ? $clog2(BEATS) : 1;

   typedef enum logic {
      IDLE   = 1'b0,
      ACCESS = 1'b1
   } state_t;

   typedef struct packed {
      logic       valid;
      logic       regWrite;
      logic       memWrite;
      logic       memToReg;
      logic       PCSrc;
      logic [3:0] WA3;
   } ctrl_t;

   // Word address of beat k; wraps modulo 2^ADDR_W by construction.
   function automatic logic [ADDR_W-1:0] beat_addr(input logic [ADDR_W-1:0] base,
                                                   input logic [K_W-1:0]    k);
      return base + ADDR_W'(k);
   endfunction

endpackage

// File: rtl/mem_beat_seq.sv
// Beat sequencer: walks a held vector across the narrow memory port one beat
// at a time, assembling read beats and flagging the final acknowledged beat.
module mem_beat_seq
   import mem_stage_wb_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              start_i,
   input  logic              active_i,
   input  logic              is_write_i,
   input  logic [ADDR_W-1:0] base_addr_i,
   input  logic [DATA_W-1:0] wdata_i,
   output logic              mem_req_o,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [BEAT_W-1:0] mem_wdata_o,
   input  logic [BEAT_W-1:0] mem_rdata_i,
   input  logic              mem_ack_i,
   output logic [DATA_W-1:0] rdata_full_o,
   output logic              last_done_o
);

   logic [K_W-1:0]    k_q;
   logic [K_W-1:0]    k_d;
   logic [BEAT_W-1:0] asm_q [BEATS];
   logic              beat_done;

   // An ack only counts while a request is actually outstanding.
   assign beat_done   = active_i & mem_ack_i;
   assign last_done_o = beat_done & (k_q == K_W'(BEATS - 1));

   assign mem_req_o  = active_i;
   assign mem_we_o   = active_i & is_write_i;
   assign mem_addr_o = beat_addr(base_addr_i, k_q);

   always_comb begin
      mem_wdata_o = '0;
      for (int i = 0; i < BEATS; i++) begin
         if (k_q == K_W'(i)) begin
            mem_wdata_o = wdata_i[i*BEAT_W +: BEAT_W];
         end
      end
   end

   always_comb begin
      k_d = k_q;
      if (start_i) begin
         k_d = '0;
      end else if (beat_done) begin
         k_d = k_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         k_q <= '0;
         for (int i = 0; i < BEATS; i++) begin
            asm_q[i] <= '0;
         end
      end else begin
         k_q <= k_d;
         if (beat_done && !is_write_i) begin
            asm_q[k_q] <= mem_rdata_i;
         end
      end
   end

   // The final beat bypasses the assembly register so writeback sees it on the same edge.
   genvar gi;
   generate
      for (gi = 0; gi < BEATS; gi++) begin : g_asm
         assign rdata_full_o[gi*BEAT_W +: BEAT_W] =
            (k_q == K_W'(gi)) ? mem_rdata_i : asm_q[gi];
      end
   endgenerate

endmodule

// File: rtl/mem_stage_wb.sv
// MEM stage of the vector ASIP: consumes EX/MEM, runs multi-beat data-memory
// accesses while stalling upstream, and loads the MEM/WB register.
module mem_stage_wb
   import mem_stage_wb_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] aluResultM,
   input  logic [DATA_W-1:0] writeDataM,
   input  logic [3:0]        WA3M,
   input  logic              validM,
   input  logic              regWriteM,
   input  logic              memWriteM,
   input  logic              memToRegM,
   input  logic              PCSrcM,
   output logic              stallM,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [BEAT_W-1:0] mem_wdata,
   input  logic [BEAT_W-1:0] mem_rdata,
   input  logic              mem_ack,
   output logic [DATA_W-1:0] aluOutW,
   output logic [DATA_W-1:0] readDataW,
   output logic [3:0]        WA3W,
   output logic              validW,
   output logic              regWriteW,
   output logic              memToRegW,
   output logic              PCSrcW
);

   state_t            state_q, state_d;
   ctrl_t             ctrl_m;
   ctrl_t             hold_ctrl_q, hold_ctrl_d;
   logic [DATA_W-1:0] hold_alu_q, hold_alu_d;
   logic [DATA_W-1:0] hold_wdata_q, hold_wdata_d;
   ctrl_t             w_ctrl_q, w_ctrl_d;
   logic [DATA_W-1:0] alu_w_q, alu_w_d;
   logic [DATA_W-1:0] rd_w_q, rd_w_d;
   logic              capture;
   logic              last_done;
   logic [DATA_W-1:0] rdata_full;

   // A store that also claims memToReg is a store; memToReg is dropped here.
   always_comb begin
      ctrl_m          = '0;
      ctrl_m.valid    = validM;
      ctrl_m.regWrite = regWriteM & validM;
      ctrl_m.memWrite = memWriteM;
      ctrl_m.memToReg = memToRegM & ~memWriteM;
      ctrl_m.PCSrc    = PCSrcM;
      ctrl_m.WA3      = WA3M;
   end

   always_comb begin
      state_d      = state_q;
      capture      = 1'b0;
      hold_ctrl_d  = hold_ctrl_q;
      hold_alu_d   = hold_alu_q;
      hold_wdata_d = hold_wdata_q;
      w_ctrl_d     = w_ctrl_q;
      alu_w_d      = alu_w_q;
      rd_w_d       = rd_w_q;
      case (state_q)
         IDLE: begin
            if (validM && (memWriteM || memToRegM)) begin
               capture           = 1'b1;
               state_d           = ACCESS;
               hold_ctrl_d       = ctrl_m;
               hold_alu_d        = aluResultM;
               hold_wdata_d      = writeDataM;
               w_ctrl_d.valid    = 1'b0;
               w_ctrl_d.regWrite = 1'b0;
            end else begin
               w_ctrl_d = ctrl_m;
               alu_w_d  = aluResultM;
            end
         end
         ACCESS: begin
            if (last_done) begin
               state_d        = IDLE;
               w_ctrl_d       = hold_ctrl_q;
               w_ctrl_d.valid = 1'b1;
               alu_w_d        = hold_alu_q;
               if (!hold_ctrl_q.memWrite) begin
                  rd_w_d = rdata_full;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= IDLE;
         hold_ctrl_q  <= '0;
         hold_alu_q   <= '0;
         hold_wdata_q <= '0;
         w_ctrl_q     <= '0;
         alu_w_q      <= '0;
         rd_w_q       <= '0;
      end else begin
         state_q      <= state_d;
         hold_ctrl_q  <= hold_ctrl_d;
         hold_alu_q   <= hold_alu_d;
         hold_wdata_q <= hold_wdata_d;
         w_ctrl_q     <= w_ctrl_d;
         alu_w_q      <= alu_w_d;
         rd_w_q       <= rd_w_d;
      end
   end

   assign stallM = (state_q == ACCESS);

   mem_beat_seq u_seq (
      .clk          (clk),
      .rst          (rst),
      .start_i      (capture),
      .active_i     (state_q == ACCESS),
      .is_write_i   (hold_ctrl_q.memWrite),
      .base_addr_i  (hold_alu_q[ADDR_W-1:0]),
      .wdata_i      (hold_wdata_q),
      .mem_req_o    (mem_req),
      .mem_we_o     (mem_we),
      .mem_addr_o   (mem_addr),
      .mem_wdata_o  (mem_wdata),
      .mem_rdata_i  (mem_rdata),
      .mem_ack_i    (mem_ack),
      .rdata_full_o (rdata_full),
      .last_done_o  (last_done)
   );

   assign aluOutW   = alu_w_q;
   assign readDataW = rd_w_q;
   assign WA3W      = w_ctrl_q.WA3;
   assign validW    = w_ctrl_q.valid;
   assign regWriteW = w_ctrl_q.regWrite;
   assign memToRegW = w_ctrl_q.memToReg;
   assign PCSrcW    = w_ctrl_q.PCSrc;

endmodule

// File: tb/tb_mem_stage_wb.sv
// Directed bench for mem_stage_wb: table of ALU/bubble vectors plus hand-written
// memory-op sequences against a small request/acknowledge memory responder.
module tb_mem_stage_wb;

   logic        clk = 1'b0;
   logic        rst;
   logic [47:0] aluResultM, writeDataM;
   logic [3:0]  WA3M;
   logic        validM, regWriteM, memWriteM, memToRegM, PCSrcM;
   logic        stallM, mem_req, mem_we;
   logic [15:0] mem_addr, mem_wdata;
   logic [15:0] mem_rdata = 16'h0;
   logic        mem_ack = 1'b0;
   logic [47:0] aluOutW, readDataW;
   logic [3:0]  WA3W;
   logic        validW, regWriteW, memToRegW, PCSrcW;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   mem_stage_wb dut (
      .clk(clk), .rst(rst),
      .aluResultM(aluResultM), .writeDataM(writeDataM), .WA3M(WA3M),
      .validM(validM), .regWriteM(regWriteM), .memWriteM(memWriteM),
      .memToRegM(memToRegM), .PCSrcM(PCSrcM),
      .stallM(stallM), .mem_req(mem_req), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ack(mem_ack),
      .aluOutW(aluOutW), .readDataW(readDataW), .WA3W(WA3W),
      .validW(validW), .regWriteW(regWriteW), .memToRegW(memToRegW), .PCSrcW(PCSrcW)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Memory responder: acks each beat after ack_delay wait cycles.
   int          ack_delay = 0;
   int          beat_cnt = 0;
   int          wcnt = 0;
   int          unstable = 0;
   logic [15:0] rd_tab [3];
   logic [15:0] p_addr, p_wdata;
   logic        p_we;
   logic [15:0] log_addr[$];
   logic [15:0] log_wdata[$];
   logic        log_we[$];

   always @(negedge clk) begin
      if (mem_ack) begin
         beat_cnt++;
         wcnt = 0;
      end
      mem_ack = 1'b0;
      if (mem_req === 1'b1) begin
         if (wcnt == 0) begin
            p_addr = mem_addr; p_wdata = mem_wdata; p_we = mem_we;
         end else if (mem_addr !== p_addr || mem_wdata !== p_wdata || mem_we !== p_we) begin
            unstable++;
         end
         if (wcnt == ack_delay) begin
            mem_ack   = 1'b1;
            mem_rdata = (beat_cnt < 3) ? rd_tab[beat_cnt] : 16'hDEAD;
            log_addr.push_back(mem_addr);
            log_wdata.push_back(mem_wdata);
            log_we.push_back(mem_we);
         end else begin
            wcnt++;
         end
      end
   end

   task automatic responder_setup(input int dly, input logic [15:0] r0, r1, r2);
      ack_delay = dly; beat_cnt = 0; wcnt = 0; unstable = 0;
      rd_tab[0] = r0; rd_tab[1] = r1; rd_tab[2] = r2;
      log_addr.delete(); log_wdata.delete(); log_we.delete();
   endtask

   task automatic drive(input logic v, rw, mw, mtr, pc, input logic [3:0] wa,
                        input logic [47:0] alu, wd);
      validM = v; regWriteM = rw; memWriteM = mw; memToRegM = mtr; PCSrcM = pc;
      WA3M = wa; aluResultM = alu; writeDataM = wd;
   endtask

   // One memory instruction; inputs are scrambled during the access to show they are ignored.
   task automatic do_mem_op(input string tag, input logic mw, mtr, rw, pc,
                            input logic [3:0] wa, input logic [47:0] alu, wd,
                            input int dly, input logic [15:0] r0, r1, r2,
                            input logic [47:0] exp_rd, input logic exp_mtr);
      int n, stall_cnt, vcnt;
      logic done;
      logic [15:0] base;
      logic [47:0] wv;
      base = alu[15:0];
      wv = wd;
      @(negedge clk);
      responder_setup(dly, r0, r1, r2);
      drive(1'b1, rw, mw, mtr, pc, wa, alu, wd);
      @(posedge clk);
      @(negedge clk);
      drive(1'b1, ~rw, 1'b0, 1'b0, ~pc, 4'hE, 48'hBAD0BAD0BAD0, 48'h5A5A5A5A5A5A);
      n = 0; stall_cnt = 0; vcnt = 0; done = 1'b0;
      while (!done && n < 200) begin
         if (validW) vcnt++;
         if (stallM) begin
            stall_cnt++;
            @(negedge clk);
            n++;
         end else begin
            done = 1'b1;
         end
      end
      check({tag, "_completes"}, 64'(done), 64'd1);
      check({tag, "_stall_cycles"}, 64'(stall_cnt), 64'(3 * (dly + 1)));
      check({tag, "_validW_pulses"}, 64'(vcnt), 64'd1);
      check({tag, "_validW"}, 64'(validW), 64'd1);
      check({tag, "_regWriteW"}, 64'(regWriteW), 64'(rw));
      check({tag, "_memToRegW"}, 64'(memToRegW), 64'(exp_mtr));
      check({tag, "_PCSrcW"}, 64'(PCSrcW), 64'(pc));
      check({tag, "_WA3W"}, 64'(WA3W), 64'(wa));
      check({tag, "_aluOutW"}, 64'(aluOutW), 64'(alu));
      check({tag, "_readDataW"}, 64'(readDataW), 64'(exp_rd));
      check({tag, "_beats"}, 64'(log_addr.size()), 64'd3);
      check({tag, "_unstable"}, 64'(unstable), 64'd0);
      for (int i = 0; i < 3 && i < log_addr.size(); i++) begin
         check($sformatf("%s_addr%0d", tag, i), 64'(log_addr[i]), 64'(16'(base + 16'(i))));
         check($sformatf("%s_we%0d", tag, i), 64'(log_we[i]), 64'(mw));
         if (mw) check($sformatf("%s_wdata%0d", tag, i), 64'(log_wdata[i]), 64'(wv[i*16 +: 16]));
      end
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 48'h0, 48'h0);
      @(negedge clk);
      check({tag, "_bubble_after"}, 64'(validW), 64'd0);
      $display("txn %s done: stall=%0d readDataW=%h", tag, stall_cnt, readDataW);
   endtask

   typedef struct {
      logic        v, rw, pc;
      logic [3:0]  wa;
      logic [47:0] alu;
      logic        e_v, e_rw, e_pc, chk;
      logic [3:0]  e_wa;
      logic [47:0] e_alu;
   } vec_t;

   vec_t tab [5];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, vcnt;
      tab[0] = '{1'b1, 1'b1, 1'b0, 4'd5,  48'h123456789ABC, 1'b1, 1'b1, 1'b0, 1'b1, 4'd5,  48'h123456789ABC};
      tab[1] = '{1'b0, 1'b1, 1'b1, 4'd3,  48'hFFFF00001111, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0,  48'h0};
      tab[2] = '{1'b1, 1'b0, 1'b1, 4'd15, 48'h000000000000, 1'b1, 1'b0, 1'b1, 1'b1, 4'd15, 48'h000000000000};
      tab[3] = '{1'b1, 1'b1, 1'b0, 4'd0,  48'hFFFFFFFFFFFF, 1'b1, 1'b1, 1'b0, 1'b1, 4'd0,  48'hFFFFFFFFFFFF};
      tab[4] = '{1'b1, 1'b1, 1'b0, 4'd9,  48'h0000DEADBEEF, 1'b1, 1'b1, 1'b0, 1'b1, 4'd9,  48'h0000DEADBEEF};

      // Reset with a memory op presented: nothing may start.
      rst = 1'b0;
      drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 4'd7, 48'h111111111111, 48'h222222222222);
      repeat (3) @(negedge clk);
      check("rst_validW", 64'(validW), 64'd0);
      check("rst_regWriteW", 64'(regWriteW), 64'd0);
      check("rst_memToRegW", 64'(memToRegW), 64'd0);
      check("rst_PCSrcW", 64'(PCSrcW), 64'd0);
      check("rst_aluOutW", 64'(aluOutW), 64'd0);
      check("rst_readDataW", 64'(readDataW), 64'd0);
      check("rst_WA3W", 64'(WA3W), 64'd0);
      check("rst_mem_req", 64'(mem_req), 64'd0);
      check("rst_mem_we", 64'(mem_we), 64'd0);
      check("rst_stallM", 64'(stallM), 64'd0);
      $display("txn reset checked");
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 48'h0, 48'h0);
      rst = 1'b1;
      @(negedge clk);
      check("post_rst_stallM", 64'(stallM), 64'd0);

      for (int i = 0; i < 5; i++) begin
         drive(tab[i].v, tab[i].rw, 1'b0, 1'b0, tab[i].pc, tab[i].wa, tab[i].alu, 48'h0);
         @(negedge clk);
         check($sformatf("vec%0d_validW", i), 64'(validW), 64'(tab[i].e_v));
         check($sformatf("vec%0d_regWriteW", i), 64'(regWriteW), 64'(tab[i].e_rw));
         check($sformatf("vec%0d_memToRegW", i), 64'(memToRegW), 64'd0);
         check($sformatf("vec%0d_stallM", i), 64'(stallM), 64'd0);
         check($sformatf("vec%0d_readDataW", i), 64'(readDataW), 64'd0);
         if (tab[i].chk) begin
            check($sformatf("vec%0d_aluOutW", i), 64'(aluOutW), 64'(tab[i].e_alu));
            check($sformatf("vec%0d_WA3W", i), 64'(WA3W), 64'(tab[i].e_wa));
            check($sformatf("vec%0d_PCSrcW", i), 64'(PCSrcW), 64'(tab[i].e_pc));
         end
         $display("txn vec%0d: validW=%b aluOutW=%h WA3W=%0d", i, validW, aluOutW, WA3W);
      end

      do_mem_op("load", 1'b0, 1'b1, 1'b1, 1'b0, 4'd7, 48'h000000000010, 48'h0,
                0, 16'h1111, 16'h2222, 16'h3333, 48'h333322221111, 1'b1);
      do_mem_op("store_wait", 1'b1, 1'b0, 1'b0, 1'b1, 4'd2, 48'h000000000100, 48'hAAAABBBBCCCC,
                2, 16'h0F0F, 16'h0F0F, 16'h0F0F, 48'h333322221111, 1'b0);
      do_mem_op("store_mtr", 1'b1, 1'b1, 1'b1, 1'b0, 4'd4, 48'h000000000200, 48'h000300020001,
                1, 16'h7777, 16'h7777, 16'h7777, 48'h333322221111, 1'b0);
      do_mem_op("wrap_load", 1'b0, 1'b1, 1'b1, 1'b0, 4'd8, 48'h12340000FFFF, 48'h0,
                0, 16'hA1A1, 16'hB2B2, 16'hC3C3, 48'hC3C3B2B2A1A1, 1'b1);

      // Reset after two beats of a load have been acknowledged.
      @(negedge clk);
      responder_setup(0, 16'h9999, 16'h8888, 16'h7777);
      drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'd6, 48'h000000000040, 48'h0);
      @(posedge clk);
      #1 drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 48'h0, 48'h0);
      @(posedge clk);
      @(posedge clk);
      #2 rst = 1'b0;
      #1;
      check("midrst_mem_req", 64'(mem_req), 64'd0);
      check("midrst_stallM", 64'(stallM), 64'd0);
      check("midrst_validW", 64'(validW), 64'd0);
      check("midrst_readDataW", 64'(readDataW), 64'd0);
      check("midrst_beats_before", 64'(log_addr.size()), 64'd2);
      @(negedge clk);
      rst = 1'b1;
      vcnt = 0;
      for (n = 0; n < 5; n++) begin
         @(negedge clk);
         if (validW) vcnt++;
      end
      check("midrst_no_writeback", 64'(vcnt), 64'd0);
      $display("txn reset mid-op checked");

      drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'hC, 48'h0A0B0C0D0E0F, 48'h0);
      @(negedge clk);
      check("post_midrst_alu_validW", 64'(validW), 64'd1);
      check("post_midrst_alu_aluOutW", 64'(aluOutW), 64'h0A0B0C0D0E0F);
      check("post_midrst_alu_WA3W", 64'(WA3W), 64'hC);
      check("post_midrst_alu_stallM", 64'(stallM), 64'd0);
      $display("txn post-reset alu: aluOutW=%h", aluOutW);
      do_mem_op("post_rst_load", 1'b0, 1'b1, 1'b1, 1'b0, 4'd1, 48'h000000000050, 48'h0,
                0, 16'h0123, 16'h4567, 16'h89AB, 48'h89AB45670123, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
